// File: rtl/pm_ladder_seq.sv
// pm_ladder_seq: Montgomery-ladder sequencer for Q = k*P over GF(2^N).
// Scans the scalar for its top set bit and handles the trivial cases (k==0, x==0, k==1) itself.
// Otherwise it drives three external engines through start/done handshakes:
//   translate (TR) -> t add-double (AD) steps -> y-recovery (REC).
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_in_valid / o_in_ready            job request; ready only in idle
//   i_din_p_x, i_din_p_y, i_random_z   base point and projective randomiser
//   i_key                              scalar k
//   i_abort                            cancel the running job (ignored in idle and output)
//   o_out_valid / i_out_ready          result handshake; result held until consumed
//   o_dout_x, o_dout_y, o_dout_inf     result point or point-at-infinity flag
//   o_busy                             not idle
//   o_px, o_py, o_pz                   latched job operands seen by the engines
//   o_tr_*, i_tr_*                     translate engine handshake and initial ladder pair
//   o_ad_*, i_ad_*                     add-double engine handshake, operands and results
//   o_rec_*, i_rec_*                   y-recovery engine handshake and affine result
module pm_ladder_seq #(
  parameter int unsigned N     = 233,
  parameter int unsigned KEY_W = 233
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [N-1:0]     i_din_p_x,
  input  logic [N-1:0]     i_din_p_y,
  input  logic [N-1:0]     i_random_z,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_abort,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [N-1:0]     o_dout_x,
  output logic [N-1:0]     o_dout_y,
  output logic             o_dout_inf,
  output logic             o_busy,
  output logic [N-1:0]     o_px,
  output logic [N-1:0]     o_py,
  output logic [N-1:0]     o_pz,
  output logic             o_tr_start,
  input  logic             i_tr_done,
  input  logic [N-1:0]     i_tr_x1,
  input  logic [N-1:0]     i_tr_z1,
  input  logic [N-1:0]     i_tr_x2,
  input  logic [N-1:0]     i_tr_z2,
  output logic             o_ad_start,
  input  logic             i_ad_done,
  output logic [N-1:0]     o_ad_p1_x,
  output logic [N-1:0]     o_ad_p1_z,
  output logic [N-1:0]     o_ad_p2_x,
  output logic [N-1:0]     o_ad_p2_z,
  input  logic [N-1:0]     i_ad_a_x,
  input  logic [N-1:0]     i_ad_a_z,
  input  logic [N-1:0]     i_ad_d_x,
  input  logic [N-1:0]     i_ad_d_z,
  output logic             o_rec_start,
  input  logic             i_rec_done,
  input  logic [N-1:0]     i_rec_x,
  input  logic [N-1:0]     i_rec_y
);

  localparam int unsigned IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [3:0] {
    StIdle, StFind, StDecide, StInit, StWaitTr, StStep, StWaitAd, StRec, StWaitRec, StOut
  } state_e;

  state_e           r_state, w_state;
  logic [N-1:0]     r_px, r_py, r_pz, w_px, w_py, w_pz;
  logic [KEY_W-1:0] r_key, w_key;
  logic [IDX_W-1:0] r_idx, w_idx, r_t, w_t;
  logic [N-1:0]     r_x1, r_z1, r_x2, r_z2, w_x1, w_z1, w_x2, w_z2;
  logic [N-1:0]     r_dout_x, r_dout_y, w_dout_x, w_dout_y;
  logic             r_dout_inf, w_dout_inf;

  logic w_bit;
  logic w_swap;
  logic w_abortable;
  logic w_key_zero;
  logic w_x_zero;

  assign w_bit       = r_key[r_idx];
  // Operands are swapped only while a ladder step is in flight; REC always sees them unswapped.
  assign w_swap      = w_bit & ((r_state == StStep) | (r_state == StWaitAd));
  assign w_abortable = (r_state != StIdle) & (r_state != StOut);
  assign w_key_zero  = ~|r_key;
  assign w_x_zero    = ~|r_px;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_px       <= '0;
      r_py       <= '0;
      r_pz       <= '0;
      r_key      <= '0;
      r_idx      <= '0;
      r_t        <= '0;
      r_x1       <= '0;
      r_z1       <= '0;
      r_x2       <= '0;
      r_z2       <= '0;
      r_dout_x   <= '0;
      r_dout_y   <= '0;
      r_dout_inf <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_px       <= w_px;
      r_py       <= w_py;
      r_pz       <= w_pz;
      r_key      <= w_key;
      r_idx      <= w_idx;
      r_t        <= w_t;
      r_x1       <= w_x1;
      r_z1       <= w_z1;
      r_x2       <= w_x2;
      r_z2       <= w_z2;
      r_dout_x   <= w_dout_x;
      r_dout_y   <= w_dout_y;
      r_dout_inf <= w_dout_inf;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_px       = r_px;
    w_py       = r_py;
    w_pz       = r_pz;
    w_key      = r_key;
    w_idx      = r_idx;
    w_t        = r_t;
    w_x1       = r_x1;
    w_z1       = r_z1;
    w_x2       = r_x2;
    w_z2       = r_z2;
    w_dout_x   = r_dout_x;
    w_dout_y   = r_dout_y;
    w_dout_inf = r_dout_inf;

    // Abort wins over any done arriving in the same cycle.
    if (i_abort && w_abortable) begin
      w_state = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            w_px    = i_din_p_x;
            w_py    = i_din_p_y;
            w_pz    = i_random_z;
            w_key   = i_key;
            w_idx   = IDX_W'(KEY_W - 1);
            w_state = StFind;
          end
        end
        StFind: begin
          if (w_bit) begin
            w_t     = r_idx;
            w_state = StDecide;
          end else if (r_idx == '0) begin
            w_t     = '0;
            w_state = StDecide;
          end else begin
            w_idx = r_idx - IDX_W'(1);
          end
        end
        StDecide: begin
          w_state = StOut;
          if (w_key_zero || (w_x_zero && !r_key[0])) begin
            w_dout_x   = '0;
            w_dout_y   = '0;
            w_dout_inf = 1'b1;
          end else if (w_x_zero) begin
            // x==0 is a point of order two: odd k gives P back.
            w_dout_x   = '0;
            w_dout_y   = r_py;
            w_dout_inf = 1'b0;
          end else if (r_t == '0) begin
            w_dout_x   = r_px;
            w_dout_y   = r_py;
            w_dout_inf = 1'b0;
          end else begin
            w_state = StInit;
          end
        end
        StInit: w_state = StWaitTr;
        StWaitTr: begin
          if (i_tr_done) begin
            w_x1    = i_tr_x1;
            w_z1    = i_tr_z1;
            w_x2    = i_tr_x2;
            w_z2    = i_tr_z2;
            w_idx   = r_t - IDX_W'(1);
            w_state = StStep;
          end
        end
        StStep: w_state = StWaitAd;
        StWaitAd: begin
          if (i_ad_done) begin
            if (w_bit) begin
              w_x1 = i_ad_a_x;
              w_z1 = i_ad_a_z;
              w_x2 = i_ad_d_x;
              w_z2 = i_ad_d_z;
            end else begin
              w_x2 = i_ad_a_x;
              w_z2 = i_ad_a_z;
              w_x1 = i_ad_d_x;
              w_z1 = i_ad_d_z;
            end
            if (r_idx == '0) begin
              w_state = StRec;
            end else begin
              w_idx   = r_idx - IDX_W'(1);
              w_state = StStep;
            end
          end
        end
        StRec: w_state = StWaitRec;
        StWaitRec: begin
          if (i_rec_done) begin
            w_dout_x   = i_rec_x;
            w_dout_y   = i_rec_y;
            w_dout_inf = 1'b0;
            w_state    = StOut;
          end
        end
        StOut: begin
          if (i_out_ready) w_state = StIdle;
        end
        default: w_state = StIdle;
      endcase
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_out_valid = (r_state == StOut);
  assign o_tr_start  = (r_state == StInit);
  assign o_ad_start  = (r_state == StStep);
  assign o_rec_start = (r_state == StRec);
  assign o_dout_x    = r_dout_x;
  assign o_dout_y    = r_dout_y;
  assign o_dout_inf  = r_dout_inf;
  assign o_px        = r_px;
  assign o_py        = r_py;
  assign o_pz        = r_pz;
  assign o_ad_p1_x   = w_swap ? r_x2 : r_x1;
  assign o_ad_p1_z   = w_swap ? r_z2 : r_z1;
  assign o_ad_p2_x   = w_swap ? r_x1 : r_x2;
  assign o_ad_p2_z   = w_swap ? r_z1 : r_z2;

endmodule

// File: tb/tb_pm_ladder_seq.sv
// Self-checking bench for pm_ladder_seq: engine models answer the start pulses with tagged
// (non-commutative) results; a scalar-level Montgomery-ladder model predicts every result.
module tb_pm_ladder_seq;

  localparam int unsigned N     = 233;
  localparam int unsigned KEY_W = 233;

  typedef logic [N-1:0]     fe_t;
  typedef logic [KEY_W-1:0] key_t;
  typedef struct {fe_t p1x; fe_t p1z; fe_t p2x; fe_t p2z;} ops_t;

  localparam fe_t K1 = fe_t'(64'h0123_4567_89ab_cdef);
  localparam fe_t K2 = fe_t'(64'hfedc_ba98_7654_3210);
  localparam fe_t K3 = fe_t'(64'h5a5a_0f0f_3c3c_9696);
  localparam fe_t K4 = fe_t'(64'h1111_2222_4444_8888);

  logic clk = 1'b0;
  logic rst_n;
  logic i_in_valid, i_out_ready;
  fe_t  i_din_p_x, i_din_p_y, i_random_z;
  key_t i_key;
  logic abort_task, abort_eng;
  wire  i_abort = abort_task | abort_eng;
  logic i_tr_done, i_ad_done, i_rec_done;
  fe_t  i_tr_x1, i_tr_z1, i_tr_x2, i_tr_z2;
  fe_t  i_ad_a_x, i_ad_a_z, i_ad_d_x, i_ad_d_z;
  fe_t  i_rec_x, i_rec_y;
  logic o_in_ready, o_out_valid, o_dout_inf, o_busy, o_tr_start, o_ad_start, o_rec_start;
  fe_t  o_dout_x, o_dout_y, o_px, o_py, o_pz;
  fe_t  o_ad_p1_x, o_ad_p1_z, o_ad_p2_x, o_ad_p2_z;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pm_ladder_seq #(.N(N), .KEY_W(KEY_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_din_p_x(i_din_p_x), .i_din_p_y(i_din_p_y), .i_random_z(i_random_z), .i_key(i_key),
    .i_abort(i_abort), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_dout_x(o_dout_x), .o_dout_y(o_dout_y), .o_dout_inf(o_dout_inf), .o_busy(o_busy),
    .o_px(o_px), .o_py(o_py), .o_pz(o_pz),
    .o_tr_start(o_tr_start), .i_tr_done(i_tr_done), .i_tr_x1(i_tr_x1), .i_tr_z1(i_tr_z1),
    .i_tr_x2(i_tr_x2), .i_tr_z2(i_tr_z2),
    .o_ad_start(o_ad_start), .i_ad_done(i_ad_done), .o_ad_p1_x(o_ad_p1_x),
    .o_ad_p1_z(o_ad_p1_z), .o_ad_p2_x(o_ad_p2_x), .o_ad_p2_z(o_ad_p2_z),
    .i_ad_a_x(i_ad_a_x), .i_ad_a_z(i_ad_a_z), .i_ad_d_x(i_ad_d_x), .i_ad_d_z(i_ad_d_z),
    .o_rec_start(o_rec_start), .i_rec_done(i_rec_done), .i_rec_x(i_rec_x), .i_rec_y(i_rec_y)
  );

  // Engine behaviour (shared by the engine models and the reference model).
  function automatic fe_t f_ax(fe_t p1x, fe_t p2x); return p1x + (p2x ^ K1); endfunction
  function automatic fe_t f_az(fe_t p1z, fe_t p2z); return (p1z ^ K2) + p2z; endfunction
  function automatic fe_t f_dx(fe_t p1x, fe_t p1z); return (p1x ^ K3) + p1z; endfunction
  function automatic fe_t f_dz(fe_t p1x, fe_t p1z); return (p1z ^ K4) + (p1x ^ K1); endfunction
  function automatic fe_t f_rx(fe_t p1x, fe_t p1z, fe_t p2x, fe_t px);
    return p1x + p1z + (p2x ^ K2) + px;
  endfunction
  function automatic fe_t f_ry(fe_t p1z, fe_t p2z, fe_t py); return (p2z ^ K4) + p1z + py;
  endfunction

  function automatic fe_t rand_fe();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[N-1:0];
  endfunction

  // ---------------- engine models ----------------
  int   n_tr = 0, n_ad = 0, n_rec = 0, n_dbl = 0, n_abort = 0;
  int   tr_cnt = 0, ad_cnt = 0, rec_cnt = 0;
  bit   ad_hold = 0, abort_on_ad = 0;
  logic tr_prev = 0, ad_prev = 0, rec_prev = 0;
  fe_t  tr_px, tr_py, tr_pz;
  ops_t ad_cap, rec_cap;
  fe_t  rec_px, rec_py;
  ops_t ad_ops[$];

  always @(negedge clk) begin
    i_tr_done = 1'b0;
    if (!rst_n) tr_cnt = 0;
    else begin
      if (tr_cnt > 0) begin
        tr_cnt--;
        if (tr_cnt == 0) begin
          i_tr_done = 1'b1;
          i_tr_x1 = tr_px + tr_pz;
          i_tr_z1 = tr_pz ^ K2;
          i_tr_x2 = (tr_px ^ K3) + tr_py;
          i_tr_z2 = tr_pz + tr_py + K4;
        end
      end
      if (o_tr_start) begin
        if (tr_prev) n_dbl++;
        n_tr++;
        tr_px = o_px; tr_py = o_py; tr_pz = o_pz;
        tr_cnt = int'($urandom_range(1, 4));
      end
    end
    tr_prev = o_tr_start;
  end

  always @(negedge clk) begin
    i_ad_done = 1'b0;
    abort_eng = 1'b0;
    if (!rst_n) ad_cnt = 0;
    else begin
      if (ad_cnt > 0) begin
        ad_cnt--;
        if (ad_cnt == 0) begin
          i_ad_done = 1'b1;
          i_ad_a_x = f_ax(ad_cap.p1x, ad_cap.p2x);
          i_ad_a_z = f_az(ad_cap.p1z, ad_cap.p2z);
          i_ad_d_x = f_dx(ad_cap.p1x, ad_cap.p1z);
          i_ad_d_z = f_dz(ad_cap.p1x, ad_cap.p1z);
          if (abort_on_ad) begin
            abort_eng = 1'b1;
            n_abort++;
          end
        end
      end
      if (o_ad_start) begin
        if (ad_prev) n_dbl++;
        n_ad++;
        ad_cap = '{o_ad_p1_x, o_ad_p1_z, o_ad_p2_x, o_ad_p2_z};
        ad_ops.push_back(ad_cap);
        ad_cnt = ad_hold ? 100000 : int'($urandom_range(1, 4));
      end
    end
    ad_prev = o_ad_start;
  end

  always @(negedge clk) begin
    i_rec_done = 1'b0;
    if (!rst_n) rec_cnt = 0;
    else begin
      if (rec_cnt > 0) begin
        rec_cnt--;
        if (rec_cnt == 0) begin
          i_rec_done = 1'b1;
          i_rec_x = f_rx(rec_cap.p1x, rec_cap.p1z, rec_cap.p2x, rec_px);
          i_rec_y = f_ry(rec_cap.p1z, rec_cap.p2z, rec_py);
        end
      end
      if (o_rec_start) begin
        if (rec_prev) n_dbl++;
        n_rec++;
        rec_cap = '{o_ad_p1_x, o_ad_p1_z, o_ad_p2_x, o_ad_p2_z};
        rec_px = o_px; rec_py = o_py;
        rec_cnt = int'($urandom_range(1, 4));
      end
    end
    rec_prev = o_rec_start;
  end

  // ---------------- reference model ----------------
  ops_t exp_ops[$];
  logic m_inf;
  fe_t  m_x, m_y;
  int   m_ad, m_tr, m_lat;

  task automatic ref_job(input fe_t x, input fe_t y, input fe_t z, input key_t key);
    int  t;
    fe_t r0x, r0z, r1x, r1z, ax, az, dx, dz;
    exp_ops.delete();
    m_inf = 1'b0; m_x = '0; m_y = '0; m_ad = 0; m_tr = 0; m_lat = -1;
    t = -1;
    for (int i = KEY_W - 1; i >= 0; i--) if (key[i]) begin t = i; break; end
    if (t < 0) begin
      m_inf = 1'b1; m_lat = KEY_W + 2;
    end else if (x == '0) begin
      m_lat = KEY_W - t + 2;
      if (key[0]) m_y = y; else m_inf = 1'b1;
    end else if (t == 0) begin
      m_lat = KEY_W + 2; m_x = x; m_y = y;
    end else begin
      m_tr = 1; m_ad = t;
      r0x = x + z; r0z = z ^ K2; r1x = (x ^ K3) + y; r1z = z + y + K4;
      for (int i = t - 1; i >= 0; i--) begin
        if (key[i]) begin
          // R0 <- R0+R1, R1 <- 2*R1 with R1 as the engine's first operand
          exp_ops.push_back('{r1x, r1z, r0x, r0z});
          ax = f_ax(r1x, r0x); az = f_az(r1z, r0z); dx = f_dx(r1x, r1z); dz = f_dz(r1x, r1z);
          r0x = ax; r0z = az; r1x = dx; r1z = dz;
        end else begin
          exp_ops.push_back('{r0x, r0z, r1x, r1z});
          ax = f_ax(r0x, r1x); az = f_az(r0z, r1z); dx = f_dx(r0x, r0z); dz = f_dz(r0x, r0z);
          r1x = ax; r1z = az; r0x = dx; r0z = dz;
        end
      end
      m_x = f_rx(r0x, r0z, r1x, x);
      m_y = f_ry(r0z, r1z, y);
    end
  endtask

  // ---------------- job driver ----------------
  int   j_lat, j_tr, j_ad, j_rec;
  bit   j_timeout, j_stable, j_ready_in_out, j_ops_ok;
  fe_t  j_x, j_y;
  logic j_inf, j_after_valid, j_after_ready, j_after_busy;

  task automatic do_job(input fe_t x, input fe_t y, input fe_t z, input key_t key,
                        input int hold, input bit abort_in_out);
    int t0, a0, r0;
    ad_ops.delete();
    t0 = n_tr; a0 = n_ad; r0 = n_rec;
    @(negedge clk);
    i_in_valid = 1'b1; i_din_p_x = x; i_din_p_y = y; i_random_z = z; i_key = key;
    @(negedge clk);
    i_in_valid = 1'b0; i_din_p_x = rand_fe(); i_din_p_y = rand_fe(); i_random_z = rand_fe();
    i_key = rand_fe();
    j_lat = 1;
    while (o_out_valid !== 1'b1 && j_lat < 4000) begin
      @(negedge clk);
      j_lat++;
    end
    j_timeout = (o_out_valid !== 1'b1);
    j_x = o_dout_x; j_y = o_dout_y; j_inf = o_dout_inf;
    j_stable = 1'b1; j_ready_in_out = o_in_ready;
    j_after_valid = 1'bx; j_after_ready = 1'bx; j_after_busy = 1'bx;
    if (!j_timeout) begin
      abort_task = abort_in_out && (hold > 0);
      repeat (hold) begin
        @(negedge clk);
        if (o_out_valid !== 1'b1 || o_dout_x !== j_x || o_dout_y !== j_y || o_dout_inf !== j_inf)
          j_stable = 1'b0;
        if (o_in_ready !== 1'b0) j_ready_in_out = 1'b1;
      end
      abort_task = 1'b0;
      // A new request offered during the output handshake must not be taken.
      i_out_ready = 1'b1; i_in_valid = 1'b1;
      @(negedge clk);
      i_out_ready = 1'b0; i_in_valid = 1'b0;
      j_after_valid = o_out_valid; j_after_ready = o_in_ready;
      @(negedge clk);
      j_after_busy = o_busy;
    end
    j_tr = n_tr - t0; j_ad = n_ad - a0; j_rec = n_rec - r0;
    j_ops_ok = (ad_ops.size() == exp_ops.size());
    if (j_ops_ok)
      foreach (exp_ops[i])
        if (ad_ops[i].p1x !== exp_ops[i].p1x || ad_ops[i].p1z !== exp_ops[i].p1z ||
            ad_ops[i].p2x !== exp_ops[i].p2x || ad_ops[i].p2z !== exp_ops[i].p2z)
          j_ops_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_vec++; if (o_in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready: got %b exp 1", o_in_ready); end
    n_vec++; if ({o_busy, o_out_valid, o_dout_inf, o_tr_start, o_ad_start, o_rec_start} !== 6'b0)
      begin n_err++; $display("FAIL reset_flags: got %b exp 000000",
        {o_busy, o_out_valid, o_dout_inf, o_tr_start, o_ad_start, o_rec_start}); end
    n_vec++; if ((o_dout_x | o_dout_y | o_px | o_py | o_pz | o_ad_p1_x | o_ad_p2_z) !== '0)
      begin n_err++; $display("FAIL reset_data: got nonzero data outputs exp 0"); end
  endtask

  // Special-case job: result, latency and zero engine usage.
  task automatic test_special(input string nm, input fe_t x, input fe_t y, input key_t key);
    fe_t z;
    z = rand_fe();
    ref_job(x, y, z, key);
    do_job(x, y, z, key, 0, 1'b0);
    n_vec++; if (j_timeout || j_inf !== m_inf || j_x !== m_x || j_y !== m_y) begin n_err++;
      $display("FAIL %s_result: got inf=%b x=%h y=%h exp inf=%b x=%h y=%h",
               nm, j_inf, j_x, j_y, m_inf, m_x, m_y); end
    n_vec++; if (j_lat !== m_lat) begin n_err++;
      $display("FAIL %s_latency: got %0d exp %0d", nm, j_lat, m_lat); end
    n_vec++; if (j_tr !== 0 || j_ad !== 0 || j_rec !== 0) begin n_err++;
      $display("FAIL %s_starts: got tr=%0d ad=%0d rec=%0d exp 0/0/0", nm, j_tr, j_ad, j_rec); end
  endtask

  task automatic test_key_zero(); test_special("key_zero", fe_t'(16'h1234), rand_fe(), '0);
  endtask

  task automatic test_x_zero();
    test_special("x0_odd", '0, fe_t'(8'h5a), key_t'(7));
    test_special("x0_even", '0, fe_t'(8'h5a), key_t'(6));
  endtask

  task automatic test_key_one(); test_special("key_one", fe_t'(8'hab), fe_t'(8'hcd), key_t'(1));
  endtask

  // Full ladder job: result, engine counts and per-step operand routing.
  task automatic test_ladder(input string nm, input fe_t x, input fe_t y, input key_t key,
                             input int hold);
    fe_t z;
    z = rand_fe();
    ref_job(x, y, z, key);
    do_job(x, y, z, key, hold, 1'b0);
    n_vec++; if (j_timeout || j_inf !== m_inf || j_x !== m_x || j_y !== m_y) begin n_err++;
      $display("FAIL %s_result: got inf=%b x=%h y=%h exp inf=%b x=%h y=%h",
               nm, j_inf, j_x, j_y, m_inf, m_x, m_y); end
    n_vec++; if (j_tr !== m_tr || j_ad !== m_ad || j_rec !== m_tr) begin n_err++;
      $display("FAIL %s_starts: got tr=%0d ad=%0d rec=%0d exp %0d/%0d/%0d",
               nm, j_tr, j_ad, j_rec, m_tr, m_ad, m_tr); end
    n_vec++; if (!j_ops_ok) begin n_err++;
      $display("FAIL %s_routing: got %0d ad ops (mismatched) exp %0d matching",
               nm, ad_ops.size(), exp_ops.size()); end
    if (m_lat >= 0) begin
      n_vec++; if (j_lat !== m_lat) begin n_err++;
        $display("FAIL %s_latency: got %0d exp %0d", nm, j_lat, m_lat); end
    end
  endtask

  task automatic test_key_1011();
    test_ladder("key_1011", rand_fe(), rand_fe(), key_t'(4'b1011), 0);
    n_vec++; if (j_ad !== 3) begin n_err++;
      $display("FAIL key_1011_ad_count: got %0d exp 3", j_ad); end
  endtask

  task automatic test_random();
    key_t k;
    fe_t  x;
    for (int it = 0; it < 12; it++) begin
      x = rand_fe();
      k = rand_fe();
      case ($urandom_range(0, 5))
        0: k = '0;
        1: begin x = '0; k = key_t'($urandom_range(1, 255)); end
        2: k = key_t'($urandom_range(2, 255));
        3: begin k = '0; k[$urandom_range(0, KEY_W - 1)] = 1'b1; end
        4: k = k >> $urandom_range(0, KEY_W - 1);
        default: ;
      endcase
      test_ladder("random", x, rand_fe(), k, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_backpressure();
    fe_t x, y, z;
    key_t k;
    x = rand_fe(); y = rand_fe(); z = rand_fe(); k = key_t'(8'h9d);
    ref_job(x, y, z, k);
    do_job(x, y, z, k, 10, 1'b1);
    n_vec++; if (!j_stable) begin n_err++;
      $display("FAIL bp_stable: got unstable OUT_VALID/DOUT exp stable for 10 cycles"); end
    n_vec++; if (j_timeout || j_x !== m_x || j_y !== m_y || j_inf !== m_inf) begin n_err++;
      $display("FAIL bp_result: got x=%h y=%h exp x=%h y=%h", j_x, j_y, m_x, m_y); end
    n_vec++; if (j_ready_in_out !== 1'b0) begin n_err++;
      $display("FAIL bp_in_ready_in_out: got %b exp 0", j_ready_in_out); end
    n_vec++; if ({j_after_valid, j_after_ready, j_after_busy} !== 3'b010) begin n_err++;
      $display("FAIL bp_handshake: got valid/ready/busy=%b exp 010",
               {j_after_valid, j_after_ready, j_after_busy}); end
  endtask

  task automatic test_abort_with_done();
    int  a0, s0;
    bit  seen, hit;
    a0 = n_abort;
    abort_on_ad = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b1; i_din_p_x = rand_fe(); i_din_p_y = rand_fe(); i_random_z = rand_fe();
    i_key = key_t'(8'hb5);
    @(negedge clk);
    i_in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (n_abort != a0) begin hit = 1'b1; break; end
    end
    abort_on_ad = 1'b0;
    n_vec++; if (!hit) begin n_err++;
      $display("FAIL abort_reach_ad: got no AD_DONE within budget exp one"); end
    @(posedge clk); #1;
    n_vec++; if ({o_in_ready, o_busy, o_out_valid} !== 3'b100) begin n_err++;
      $display("FAIL abort_idle: got ready/busy/valid=%b exp 100",
               {o_in_ready, o_busy, o_out_valid}); end
    seen = 1'b0; s0 = n_ad + n_rec;
    repeat (30) begin @(negedge clk); if (o_out_valid !== 1'b0) seen = 1'b1; end
    n_vec++; if (seen || (n_ad + n_rec) != s0) begin n_err++;
      $display("FAIL abort_quiet: got valid_seen=%b extra_starts=%0d exp 0/0",
               seen, n_ad + n_rec - s0); end
  endtask

  task automatic test_reset_mid_wait();
    int  a0, s0;
    bit  hit, busy_seen;
    a0 = n_ad;
    ad_hold = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b1; i_din_p_x = rand_fe(); i_din_p_y = rand_fe(); i_random_z = rand_fe();
    i_key = key_t'(8'h2c);
    @(negedge clk);
    i_in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (n_ad != a0) begin hit = 1'b1; break; end
    end
    n_vec++; if (!hit) begin n_err++;
      $display("FAIL rst_reach_ad: got no AD_START within budget exp one"); end
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    ad_hold = 1'b0;
    test_reset();
    s0 = n_tr + n_ad + n_rec; busy_seen = 1'b0;
    repeat (8) begin @(negedge clk); if (o_busy !== 1'b0) busy_seen = 1'b1; end
    n_vec++; if (busy_seen || (n_tr + n_ad + n_rec) != s0) begin n_err++;
      $display("FAIL rst_quiet: got busy_seen=%b extra_starts=%0d exp 0/0",
               busy_seen, n_tr + n_ad + n_rec - s0); end
  endtask

  task automatic test_back_to_back();
    test_ladder("after_rst", rand_fe(), rand_fe(), key_t'(16'hc3a5), 1);
    test_ladder("b2b", rand_fe(), rand_fe(), key_t'(5'b10110), 0);
    n_vec++; if (n_dbl !== 0) begin n_err++;
      $display("FAIL start_pulse_width: got %0d multi-cycle starts exp 0", n_dbl); end
  endtask

  initial begin
    rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; abort_task = 1'b0;
    i_din_p_x = '0; i_din_p_y = '0; i_random_z = '0; i_key = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_key_zero();
    test_x_zero();
    test_key_one();
    test_key_1011();
    test_random();
    test_backpressure();
    test_abort_with_done();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
